// File: rtl/lsu_pkg.sv
// Shared encodings and alignment helper for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4,
    ERR  = 3'd5
  } lsuState_e;

  // The illegal size encoding is reported through the same error path as misalignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addrLo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addrLo[0];
      SZ_WORD: misaligned = (addrLo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Byte/half lane steering: load extract with sign/zero extension, and store merge
// of a sub-word into an existing memory word.
module lsu_lane_unit
  import lsu_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic [Width-1:0] word,
  input  logic [1:0]       addrLo,
  input  logic [1:0]       size,
  input  logic             isUnsigned,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] loadResult,
  output logic [Width-1:0] storeWord
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    case (addrLo)
      2'd0:    byteLane = word[7:0];
      2'd1:    byteLane = word[15:8];
      2'd2:    byteLane = word[23:16];
      default: byteLane = word[31:24];
    endcase
    halfLane = addrLo[1] ? word[31:16] : word[15:0];

    case (size)
      SZ_BYTE: loadResult = isUnsigned ? {24'd0, byteLane} : {{24{byteLane[7]}}, byteLane};
      SZ_HALF: loadResult = isUnsigned ? {16'd0, halfLane} : {{16{halfLane[15]}}, halfLane};
      default: loadResult = word;
    endcase
  end

  // Store data always comes from the low bits of wdata regardless of the target lane.
  always_comb begin
    storeWord = word;
    case (size)
      SZ_BYTE: begin
        case (addrLo)
          2'd0:    storeWord[7:0]   = wdata[7:0];
          2'd1:    storeWord[15:8]  = wdata[7:0];
          2'd2:    storeWord[23:16] = wdata[7:0];
          default: storeWord[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addrLo[1]) storeWord[31:16] = wdata[15:0];
        else           storeWord[15:0]  = wdata[15:0];
      end
      default: storeWord = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: turns byte-addressed loads/stores into word accesses,
// using read-modify-write for sub-word stores since the memory has no byte enables.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int Width    = 32,
  parameter int AddrBits = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [31:0]         req_addr,
  input  logic [Width-1:0]    req_wdata,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [Width-1:0]    resp_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [AddrBits-1:0] mem_addr,
  output logic [Width-1:0]    mem_wdata,
  input  logic [Width-1:0]    mem_rdata,
  output logic [2:0]          dbgState
);

  // Handshake: a request transfers on the rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and each accepted request yields exactly one
  // resp_valid pulse (resp_err qualifies it).

  lsuState_e        state;
  logic             weQ;
  logic [1:0]       sizeQ;
  logic             unsQ;
  logic [1:0]       addrLoQ;
  logic [Width-1:0] wdataQ;
  logic [Width-1:0] loadWord;
  logic [Width-1:0] mergedWord;
  logic [31-AddrBits-2:0] unusedAddrHigh;

  assign unusedAddrHigh = req_addr[31:AddrBits+2];
  assign req_ready      = (state == IDLE);
  assign dbgState       = state;

  lsu_lane_unit #(.Width(Width)) laneUnit (
    .word       (mem_rdata),
    .addrLo     (addrLoQ),
    .size       (sizeQ),
    .isUnsigned (unsQ),
    .wdata      (wdataQ),
    .loadResult (loadWord),
    .storeWord  (mergedWord)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      weQ        <= 1'b0;
      sizeQ      <= SZ_BYTE;
      unsQ       <= 1'b0;
      addrLoQ    <= 2'b00;
      wdataQ     <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      // Strobes and the response pulse are single-cycle by default.
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            weQ      <= req_we;
            sizeQ    <= req_size;
            unsQ     <= req_unsigned;
            addrLoQ  <= req_addr[1:0];
            wdataQ   <= req_wdata;
            mem_addr <= req_addr[AddrBits+1:2];
            if (misaligned(req_size, req_addr[1:0])) begin
              state      <= ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_we || (req_size != SZ_WORD)) begin
              state    <= RD;
              mem_read <= 1'b1;
            end else begin
              state     <= WR;
              mem_write <= 1'b1;
              mem_wdata <= req_wdata;
            end
          end
        end
        RD: state <= CAP;
        CAP: begin
          if (!weQ) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= loadWord;
          end else begin
            state     <= WR;
            mem_write <= 1'b1;
            mem_wdata <= mergedWord;
          end
        end
        WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        RESP:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory and
// queue-based scoreboards for responses, memory reads and memory writes.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int Width    = 32;
  localparam int AddrBits = 8;
  localparam int W        = 49;  // {resp cycle[15:0], err, rdata[31:0]}

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic                req_we = 1'b0;
  logic [1:0]          req_size = 2'b00;
  logic                req_unsigned = 1'b0;
  logic [31:0]         req_addr = '0;
  logic [Width-1:0]    req_wdata = '0;
  logic                resp_valid;
  logic                resp_err;
  logic [Width-1:0]    resp_rdata;
  logic                mem_read;
  logic                mem_write;
  logic [AddrBits-1:0] mem_addr;
  logic [Width-1:0]    mem_wdata;
  logic [Width-1:0]    mem_rdata = '0;
  logic [2:0]          dbgState;

  load_store_unit #(.Width(Width), .AddrBits(AddrBits)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbgState(dbgState)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural memory ----------------
  logic [Width-1:0] mem [256];
  logic             preloadEn = 1'b0;
  logic [7:0]       preloadAddr = '0;
  logic [31:0]      preloadData = '0;

  always @(posedge clk) begin
    if (mem_write)      mem[mem_addr] <= mem_wdata;
    else if (preloadEn) mem[preloadAddr] <= preloadData;
    if (mem_read)       mem_rdata <= mem[mem_addr];
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [39:0]  wr_q[$];
  logic [7:0]   rd_q[$];
  int checks = 0;
  int fails  = 0;
  int respCount = 0;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    fails++;
    $display("FAIL %s: unexpected event (t=%0t)", name, $time);
  endtask

  // Monitor: pops an expectation whenever the DUT presents a response or strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      check_val("strobe_exclusive", {63'd0, mem_read & mem_write}, 64'd0);
      if (resp_valid) begin
        logic [W-1:0] e;
        respCount++;
        if (exp_q.size() == 0) flag("unexpected_resp");
        else begin
          e = exp_q.pop_front();
          check_val("resp_cycle", {48'd0, cyc[15:0]}, {48'd0, e[48:33]});
          check_val("resp_err",   {63'd0, resp_err}, {63'd0, e[32]});
          check_val("resp_rdata", {32'd0, resp_rdata}, {32'd0, e[31:0]});
        end
      end
      if (mem_read) begin
        logic [7:0] a;
        if (rd_q.size() == 0) flag("unexpected_mem_read");
        else begin
          a = rd_q.pop_front();
          check_val("read_addr", {56'd0, mem_addr}, {56'd0, a});
        end
      end
      if (mem_write) begin
        logic [39:0] w;
        if (wr_q.size() == 0) flag("unexpected_mem_write");
        else begin
          w = wr_q.pop_front();
          check_val("write_addr",  {56'd0, mem_addr}, {56'd0, w[39:32]});
          check_val("write_wdata", {32'd0, mem_wdata}, {32'd0, w[31:0]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int lat, input logic expErr, input logic [31:0] expRdata,
                       input logic expectResp, output int acc);
    int waitCnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    while (!req_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!req_ready) flag("accept_timeout");
    acc = cyc;
    if (expectResp) exp_q.push_back({16'(cyc + lat), expErr, expRdata});
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rd_q.size() != 0 || wr_q.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || rd_q.size() != 0 || wr_q.size() != 0) flag("drain_timeout");
    @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    preloadEn = 1'b1; preloadAddr = a; preloadData = d;
    @(negedge clk);
    preloadEn = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                         input logic [31:0] expv);
    int acc;
    rd_q.push_back(addr[9:2]);
    issue(1'b0, size, uns, addr, 32'd0, 3, 1'b0, expv, 1'b1, acc);
    go_idle();
    drain();
  endtask

  task automatic do_error(input logic we, input logic [1:0] size, input logic [31:0] addr);
    int acc;
    issue(we, size, 1'b0, addr, 32'hDEADBEEF, 1, 1'b1, 32'd0, 1'b1, acc);
    go_idle();
    drain();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc, acc2, respBefore;

    // reset state
    #1;
    check_val("rst_req_ready",  {63'd0, req_ready}, 64'd1);
    check_val("rst_mem_read",   {63'd0, mem_read}, 64'd0);
    check_val("rst_mem_write",  {63'd0, mem_write}, 64'd0);
    check_val("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check_val("rst_resp_err",   {63'd0, resp_err}, 64'd0);
    check_val("rst_mem_addr",   {56'd0, mem_addr}, 64'd0);
    check_val("rst_mem_wdata",  {32'd0, mem_wdata}, 64'd0);
    check_val("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // word store then load
    wr_q.push_back({8'h04, 32'hAAAAAAAA});
    issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hAAAAAAAA, 2, 1'b0, 32'd0, 1'b1, acc);
    go_idle();
    drain();
    do_load(SZ_WORD, 1'b0, 32'h10, 32'hAAAAAAAA);

    // byte and halfword loads
    preload(8'h04, 32'h80FF7F01);
    do_load(SZ_BYTE, 1'b0, 32'h12, 32'hFFFFFFFF);
    do_load(SZ_BYTE, 1'b1, 32'h12, 32'h000000FF);
    do_load(SZ_BYTE, 1'b0, 32'h13, 32'hFFFFFF80);
    do_load(SZ_BYTE, 1'b0, 32'h10, 32'h00000001);
    do_load(SZ_HALF, 1'b0, 32'h12, 32'hFFFF80FF);
    do_load(SZ_HALF, 1'b1, 32'h10, 32'h00007F01);
    // high address bits wrap: 0x410 maps to word 4 as well
    do_load(SZ_WORD, 1'b0, 32'h0000_0410, 32'h80FF7F01);

    // sub-word stores (read-modify-write)
    preload(8'h04, 32'h11223344);
    rd_q.push_back(8'h04);
    wr_q.push_back({8'h04, 32'h1122EE44});
    issue(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h000000EE, 4, 1'b0, 32'd0, 1'b1, acc);
    go_idle();
    drain();
    check_val("mem_after_sb", {32'd0, mem[4]}, {32'd0, 32'h1122EE44});
    rd_q.push_back(8'h04);
    wr_q.push_back({8'h04, 32'hBEEFEE44});
    issue(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000BEEF, 4, 1'b0, 32'd0, 1'b1, acc);
    go_idle();
    drain();
    check_val("mem_after_sh", {32'd0, mem[4]}, {32'd0, 32'hBEEFEE44});

    // misaligned / illegal
    do_error(1'b0, SZ_WORD, 32'h11);
    do_error(1'b1, SZ_HALF, 32'h13);
    do_error(1'b0, 2'b11, 32'h10);
    check_val("mem_after_errors", {32'd0, mem[4]}, {32'd0, 32'hBEEFEE44});

    // reset in the middle of a read-modify-write
    preload(8'h05, 32'h55667788);
    rd_q.push_back(8'h05);
    issue(1'b1, SZ_BYTE, 1'b0, 32'h14, 32'h00000099, 4, 1'b0, 32'd0, 1'b0, acc);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_val("rmw_in_cap", {61'd0, dbgState}, {61'd0, 3'(CAP)});
    rst_n = 1'b0;
    #1;
    check_val("midrst_mem_read",   {63'd0, mem_read}, 64'd0);
    check_val("midrst_mem_write",  {63'd0, mem_write}, 64'd0);
    check_val("midrst_req_ready",  {63'd0, req_ready}, 64'd1);
    check_val("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_val("midrst_mem_word", {32'd0, mem[5]}, {32'd0, 32'h55667788});
    check_val("midrst_no_pending", {32'd0, 32'(rd_q.size())}, 64'd0);

    // back-to-back with req_valid held
    preload(8'h00, 32'h01020304);
    preload(8'h01, 32'h05060708);
    respBefore = respCount;
    rd_q.push_back(8'h00);
    rd_q.push_back(8'h01);
    issue(1'b0, SZ_WORD, 1'b0, 32'h0, 32'd0, 3, 1'b0, 32'h01020304, 1'b1, acc);
    issue(1'b0, SZ_WORD, 1'b0, 32'h4, 32'd0, 3, 1'b0, 32'h05060708, 1'b1, acc2);
    go_idle();
    drain();
    repeat (4) @(negedge clk);
    check_val("b2b_accept_gap", {32'd0, 32'(acc2 - acc)}, 64'd4);
    check_val("b2b_resp_count", {32'd0, 32'(respCount - respBefore)}, 64'd2);

    check_val("final_exp_q", {32'd0, 32'(exp_q.size())}, 64'd0);
    check_val("final_wr_q",  {32'd0, 32'(wr_q.size())}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: sits between the execute stage and the data memory and drives mem_read/mem_write/mem_addr/mem_wdata.
- Converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word-wide memory accesses.
- Sub-word stores use read-modify-write because the memory has no byte enables.
- Valid/ready request handshake toward the pipeline; one-cycle response pulse back.

Parameters:
Width, 32, data word width; only 32 is supported.
AddrBits, 8, memory word-address width; the memory holds 2^AddrBits words.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  unit idle and able to accept; combinational, equal to (state==IDLE)
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  zero-extend loads (LBU/LHU)
req_addr  in  32  byte address
req_wdata  in  Width  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  qualifies resp_valid: misaligned or illegal size
resp_rdata  out  Width  extended load data
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  AddrBits  word address = req_addr[AddrBits+1:2]
mem_wdata  out  Width  word to write
mem_rdata  in  Width  memory data; valid in the cycle after the one where mem_read=1

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - mem_read, mem_write, resp_valid and resp_err = 0.
  - mem_addr, mem_wdata and resp_rdata = 0.
  - req_ready reads 1.
- Reset mid-operation: the transaction is dropped, strobes fall immediately, no response is issued, and memory contents are whatever prior edges wrote.
- All outputs except req_ready are registered.
- Accept: a request is accepted on a clock edge with req_valid&&req_ready. At that edge the unit latches req_we, req_size, req_unsigned, req_addr[1:0], the word address and req_wdata.
- FSM states: IDLE, RD, CAP, WR, RESP, ERR.
- Transitions:
  - IDLE, on accept:
    - size==11, or half with addr[0]=1, or word with addr[1:0]!=0 -> ERR.
    - load or sub-word store -> RD.
    - word store -> WR.
  - RD: mem_read=1 and mem_addr driven for exactly one cycle -> CAP.
  - CAP, mem_rdata valid:
    - load: select lane (byte lane = addr[1:0], half lane = addr[1]), sign- or zero-extend into the result register -> RESP.
    - store: merge the store byte/half into the lane of mem_rdata, keeping the other bits -> WR.
  - WR: mem_write=1 with mem_addr and mem_wdata for exactly one cycle -> RESP.
  - RESP: resp_valid=1, resp_err=0 -> IDLE.
  - ERR: resp_valid=1, resp_err=1, no memory strobe -> IDLE.
- Latency from the accept edge to resp_valid:
  - load: 3 cycles.
  - word store: 2 cycles.
  - sub-word store: 4 cycles.
  - error: 1 cycle.
- req_ready returns to 1 in the cycle after RESP/ERR; back-to-back requests are accepted then.
- resp_rdata:
  - loads: updated in RESP.
  - stores and errors: cleared to 0.
  - otherwise holds its value.
- mem_read and mem_write are never both 1.
- mem_addr and mem_wdata hold their last values while idle.
- req_* inputs are ignored outside IDLE.
- req_addr bits above AddrBits+1 are ignored (address wraps modulo memory size).
- Store data lane source: the low 8 or 16 bits of req_wdata, whatever the address.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encoding.
  - function misaligned(size, addr_lo).
- Sub-module lsu_lane_unit (combinational):
  - load extract/extend, from (word, addr_lo, size, unsigned) -> result.
  - store merge, from (old_word, wdata, addr_lo, size) -> new_word.
  - Instantiated once in load_store_unit.

Test Plan:
- Word store then load:
  - SW addr=0x10 wdata=0xAAAAAAAA -> mem_write one cycle with mem_addr=0x04 and mem_wdata=0xAAAAAAAA; resp_valid 2 cycles after accept.
  - LW addr=0x10 -> mem_read one cycle; resp_rdata=0xAAAAAAAA 3 cycles after accept.
- Byte loads: memory word 4 = 0x80FF7F01.
  - LB 0x12 -> 0xFFFFFFFF.
  - LBU 0x12 -> 0x000000FF.
  - LB 0x13 -> 0xFFFFFF80.
  - LB 0x10 -> 0x00000001.
- Halfword loads:
  - LH 0x12 -> 0xFFFF80FF.
  - LHU 0x10 -> 0x00007F01.
- Sub-word store (RMW): memory word 4 = 0x11223344.
  - SB addr=0x11 wdata=0x000000EE -> strobe sequence mem_read, (capture), mem_write with mem_wdata=0x1122EE44; resp 4 cycles after accept.
  - SH addr=0x12 wdata=0xBEEF -> 0xBEEFEE44.
- Misaligned/illegal:
  - LW 0x11, SH 0x13 and size=11 -> resp_valid=1 with resp_err=1 one cycle after accept.
  - mem_read and mem_write stay 0 throughout.
  - Prior memory contents unchanged.
- Reset mid-RMW: assert rst_n=0 while in CAP of SB -> strobes 0 immediately, req_ready=1, no resp_valid, memory word unchanged.
- Handshake: hold req_valid=1 with back-to-back LW 0x0 and LW 0x4 -> second accepted only when req_ready=1 (cycle after RESP); exactly two resp_valid pulses; mem_read and mem_write never both 1 (checked every cycle).
